// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port unified memory between the instruction-fetch stage
// and the data load/store stage. One requester is granted at a time, the
// access is held on the bus for MEM_LAT cycles, the owner gets a one-cycle
// ready strobe with the returned data, and stall freezes the pipeline while
// any request is outstanding.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   if_req/if_adr        fetch request and address (held until if_ready)
//   if_data/if_ready     fetched word, valid only while if_ready=1
//   d_read/d_write       load/store request (held until d_ready)
//   d_adr/d_wdata        data address and store data
//   d_rdata/d_ready      load data, valid only while d_ready=1
//   stall                freeze PC and pipeline registers
//   mem_adr/mem_wdata    memory address and write data
//   mem_rd/mem_wr        memory read/write enables
//   mem_rdata            memory read data, valid in last window cycle
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_adr,
    output logic [DW-1:0] if_data,
    output logic          if_ready,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_adr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          stall,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_INST = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_inst_q, last_inst_d;   // 1: last grant went to fetch
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;

    logic            d_pend;
    logic            grant_data;
    logic            grant_inst;
    logic            last_cycle;

    // Round-robin tie-break: data wins unless it was granted last time
    assign d_pend     = d_read | d_write;
    assign grant_data = d_pend & (~if_req | last_inst_q);
    assign grant_inst = if_req & ~grant_data;

    // State and bus registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            last_inst_q <= 1'b1;
            adr_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_inst_q <= last_inst_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
        end
    end

    // Next-state: grant in IDLE, count down the window, clear bus at its end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_inst_d = last_inst_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d     = S_DATA;
                    cnt_d       = CW'(MEM_LAT - 1);
                    last_inst_d = 1'b0;
                    adr_d       = d_adr;
                    wdata_d     = d_wdata;
                    // read+write together is treated as a write
                    wr_d        = d_write;
                    rd_d        = ~d_write;
                end else if (grant_inst) begin
                    state_d     = S_INST;
                    cnt_d       = CW'(MEM_LAT - 1);
                    last_inst_d = 1'b1;
                    adr_d       = if_adr;
                    wdata_d     = '0;
                    rd_d        = 1'b1;
                    wr_d        = 1'b0;
                end
            end
            S_DATA, S_INST: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    adr_d   = '0;
                    wdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                adr_d   = '0;
                wdata_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Outputs: ready strobes in the last window cycle, suppressed under reset
    always_comb begin
        last_cycle = (cnt_q == '0);
        if_ready   = ~rst & (state_q == S_INST) & last_cycle;
        d_ready    = ~rst & (state_q == S_DATA) & last_cycle;
        if_data    = if_ready ? mem_rdata : '0;
        d_rdata    = d_ready  ? mem_rdata : '0;
        stall      = (if_req & ~if_ready) | (d_pend & ~d_ready);
    end

    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with MEM_LAT=2. Each step advances one
// clock, drives the inputs for that cycle, then checks the outputs.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_data;
    logic        if_ready;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        stall;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_data   (if_data),
        .if_ready  (if_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_adr     (d_adr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .stall     (stall),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset held with all requests high
        rst = 1'b1; if_req = 1'b1; d_read = 1'b1; d_write = 1'b1;
        if_adr = '0; d_adr = '0; d_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("rst_mem_rd",   32'(mem_rd),   32'd0);
            check("rst_mem_wr",   32'(mem_wr),   32'd0);
            check("rst_if_ready", 32'(if_ready), 32'd0);
            check("rst_d_ready",  32'(d_ready),  32'd0);
            check("rst_stall",    32'(stall),    32'd1);
        end
        check("rst_mem_adr", mem_adr, 32'd0);

        // 2: single fetch
        tick(); rst = 1'b0; d_read = 1'b0; d_write = 1'b0;
        if_req = 1'b1; if_adr = 32'h40; mem_rdata = 32'h8C010004; settle();
        check("f_c0_stall",  32'(stall),  32'd1);
        check("f_c0_mem_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        check("f_c1_mem_rd",   32'(mem_rd),   32'd1);
        check("f_c1_mem_adr",  mem_adr,       32'h40);
        check("f_c1_if_ready", 32'(if_ready), 32'd0);
        check("f_c1_stall",    32'(stall),    32'd1);
        tick(); settle();
        check("f_c2_mem_rd",   32'(mem_rd),   32'd1);
        check("f_c2_mem_adr",  mem_adr,       32'h40);
        check("f_c2_if_ready", 32'(if_ready), 32'd1);
        check("f_c2_if_data",  if_data,       32'h8C010004);
        check("f_c2_stall",    32'(stall),    32'd0);
        tick(); if_req = 1'b0; settle();
        check("f_c3_mem_rd",   32'(mem_rd),   32'd0);
        check("f_c3_if_ready", 32'(if_ready), 32'd0);
        check("f_c3_stall",    32'(stall),    32'd0);

        // 3: fetch and load together; last grant was fetch so data goes first
        tick(); if_req = 1'b1; if_adr = 32'h80; d_read = 1'b1; d_adr = 32'h200;
        mem_rdata = 32'h11112222; settle();
        check("t_c0_stall", 32'(stall), 32'd1);
        tick(); settle();
        check("t_c1_mem_rd",  32'(mem_rd),  32'd1);
        check("t_c1_mem_adr", mem_adr,      32'h200);
        check("t_c1_d_ready", 32'(d_ready), 32'd0);
        check("t_c1_stall",   32'(stall),   32'd1);
        tick(); settle();
        check("t_c2_d_ready",  32'(d_ready),  32'd1);
        check("t_c2_d_rdata",  d_rdata,       32'h11112222);
        check("t_c2_if_ready", 32'(if_ready), 32'd0);
        check("t_c2_stall",    32'(stall),    32'd1);
        tick(); d_read = 1'b0; settle();
        check("t_c3_mem_rd", 32'(mem_rd), 32'd0);
        check("t_c3_stall",  32'(stall),  32'd1);
        tick(); mem_rdata = 32'h33334444; settle();
        check("t_c4_mem_rd",  32'(mem_rd), 32'd1);
        check("t_c4_mem_adr", mem_adr,     32'h80);
        check("t_c4_stall",   32'(stall),  32'd1);
        tick(); settle();
        check("t_c5_if_ready", 32'(if_ready), 32'd1);
        check("t_c5_if_data",  if_data,       32'h33334444);
        check("t_c5_stall",    32'(stall),    32'd0);
        tick(); if_req = 1'b0; settle();
        check("t_c6_mem_rd", 32'(mem_rd), 32'd0);

        // 4: store, address changes mid-window
        tick(); d_write = 1'b1; d_adr = 32'h100; d_wdata = 32'hDEADBEEF; settle();
        check("w_c0_mem_wr", 32'(mem_wr), 32'd0);
        tick(); d_adr = 32'h104; settle();
        check("w_c1_mem_wr",    32'(mem_wr), 32'd1);
        check("w_c1_mem_rd",    32'(mem_rd), 32'd0);
        check("w_c1_mem_adr",   mem_adr,     32'h100);
        check("w_c1_mem_wdata", mem_wdata,   32'hDEADBEEF);
        tick(); settle();
        check("w_c2_mem_wr",    32'(mem_wr),  32'd1);
        check("w_c2_mem_adr",   mem_adr,      32'h100);
        check("w_c2_mem_wdata", mem_wdata,    32'hDEADBEEF);
        check("w_c2_d_ready",   32'(d_ready), 32'd1);
        tick(); d_write = 1'b0; settle();
        check("w_c3_mem_wr",  32'(mem_wr),  32'd0);
        check("w_c3_mem_adr", mem_adr,      32'd0);
        check("w_c3_d_ready", 32'(d_ready), 32'd0);

        // 5: reset in first cycle of a fetch window
        tick(); if_req = 1'b1; if_adr = 32'h44; mem_rdata = 32'hCAFE0001; settle();
        tick(); rst = 1'b1; settle();
        check("r_c1_mem_rd",   32'(mem_rd),   32'd1);
        check("r_c1_if_ready", 32'(if_ready), 32'd0);
        check("r_c1_stall",    32'(stall),    32'd1);
        tick(); rst = 1'b0; settle();
        check("r_c2_mem_rd",   32'(mem_rd),   32'd0);
        check("r_c2_if_ready", 32'(if_ready), 32'd0);
        tick(); settle();
        check("r_c3_mem_rd",   32'(mem_rd),   32'd1);
        check("r_c3_mem_adr",  mem_adr,       32'h44);
        check("r_c3_if_ready", 32'(if_ready), 32'd0);
        tick(); settle();
        check("r_c4_if_ready", 32'(if_ready), 32'd1);
        check("r_c4_if_data",  if_data,       32'hCAFE0001);
        tick(); if_req = 1'b0; settle();
        check("r_c5_mem_rd", 32'(mem_rd), 32'd0);

        // 6: fetch request dropped mid-window
        tick(); if_req = 1'b1; if_adr = 32'h48; mem_rdata = 32'h00000055; settle();
        tick(); if_req = 1'b0; settle();
        check("d_c1_mem_rd", 32'(mem_rd), 32'd1);
        check("d_c1_stall",  32'(stall),  32'd0);
        tick(); settle();
        check("d_c2_if_ready", 32'(if_ready), 32'd1);
        check("d_c2_if_data",  if_data,       32'h00000055);
        tick(); settle();
        check("d_c3_mem_rd",  32'(mem_rd), 32'd0);
        check("d_c3_mem_adr", mem_adr,     32'd0);
        tick(); settle();
        check("d_c4_mem_rd", 32'(mem_rd), 32'd0);

        // 7: read+write treated as write, then tie after data grant -> fetch
        tick(); d_read = 1'b1; d_write = 1'b1; d_adr = 32'h300; d_wdata = 32'hA5; settle();
        tick(); settle();
        check("x_c1_mem_wr",    32'(mem_wr), 32'd1);
        check("x_c1_mem_rd",    32'(mem_rd), 32'd0);
        check("x_c1_mem_wdata", mem_wdata,   32'hA5);
        tick(); settle();
        check("x_c2_d_ready", 32'(d_ready), 32'd1);
        tick(); d_write = 1'b0; d_adr = 32'h304; if_req = 1'b1; if_adr = 32'h60;
        mem_rdata = 32'h77; settle();
        check("x_c3_stall", 32'(stall), 32'd1);
        tick(); settle();
        check("x_c4_mem_rd",  32'(mem_rd), 32'd1);
        check("x_c4_mem_adr", mem_adr,     32'h60);
        tick(); settle();
        check("x_c5_if_ready", 32'(if_ready), 32'd1);
        check("x_c5_d_ready",  32'(d_ready),  32'd0);
        tick(); if_req = 1'b0; settle();
        check("x_c6_mem_rd", 32'(mem_rd), 32'd0);
        tick(); settle();
        check("x_c7_mem_rd",  32'(mem_rd), 32'd1);
        check("x_c7_mem_adr", mem_adr,     32'h304);
        tick(); settle();
        check("x_c8_d_ready", 32'(d_ready), 32'd1);
        check("x_c8_d_rdata", d_rdata,      32'h77);
        tick(); d_read = 1'b0; settle();
        check("x_c9_stall", 32'(stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
